// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg: funct3 encodings, responder FSM states and wait-counter width for the M-stage data memory.
package rv32_mem_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam int WAIT_W = 4;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_t;
endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: store byte enables and lane replication, load extraction and extension, alignment check.
module dmem_lane_fmt
    import rv32_mem_pkg::*;
(
    input  logic        wr,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        misalign
);
    logic        byt, half;
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        // Stores decode size only from the exact SB/SH codes; loads fold LBU/LHU onto byte/half.
        byt      = wr ? funct3 == F3_SB : funct3[1:0] == 2'b00;
        half     = wr ? funct3 == F3_SH : funct3[1:0] == 2'b01;
        be       = byt ? 4'b0001 << addr : half ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wword    = byt ? {4{wdata[7:0]}} : half ? {2{wdata[15:0]}} : wdata;
        b        = 8'(rword >> {addr, 3'b000});
        h        = addr[1] ? rword[31:16] : rword[15:0];
        rdata    = funct3 == F3_LB  ? {{24{b[7]}}, b} :
                   funct3 == F3_LBU ? {24'd0, b} :
                   funct3 == F3_LH  ? {{16{h[15]}}, h} :
                   funct3 == F3_LHU ? {16'd0, h} : rword;
        misalign = half ? addr[0] : !byt && addr != 2'b00;
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: M-stage data memory with WAIT_STATES wait cycles and a pipeline stall request.
module dmem_responder
  import rv32_mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_m,
  input  logic        MemWrite_m,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] ALUResult_m,
  input  logic [31:0] WriteData_m,
  output logic [31:0] ReadData_m,
  output logic        resp_valid,
  output logic        mem_stall,
  output logic        misalign_m
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]       mem [DEPTH];
  dmem_state_t       state;
  logic [WAIT_W-1:0] cnt;
  logic [31:0]       rdata_q, wword, fmt_rdata;
  logic [3:0]        be;
  logic              ld_q, mis_q, mis, fmt_mis, req, access, wr_en, unused;
  logic [AW-1:0]     idx;
  assign idx    = ALUResult_m[AW+1:2];
  assign req    = MemRead_m | MemWrite_m;
  assign access = state == BUSY && cnt == '0;
  assign wr_en  = access && MemWrite_m && !mis;
  dmem_lane_fmt u_fmt (
    .wr       (MemWrite_m),
    .funct3   (funct3_m),
    .addr     (ALUResult_m[1:0]),
    .wdata    (WriteData_m),
    .rword    (rdata_q),
    .be       (be),
    .wword    (wword),
    .rdata    (fmt_rdata),
    .misalign (fmt_mis)
  );
`ifdef DMEM_MISALIGN_CHK_EN
  assign mis        = fmt_mis;
  assign misalign_m = state == DONE && mis_q;
  assign unused     = ^ALUResult_m[31:AW+2];
`else
  assign mis        = 1'b0;
  assign misalign_m = 1'b0;
  assign unused     = ^{ALUResult_m[31:AW+2], fmt_mis, mis_q};
`endif
  assign mem_stall  = (state == IDLE && req) || state == BUSY;
  assign resp_valid = state == DONE;
  assign ReadData_m = state == DONE && ld_q ? fmt_rdata : 32'd0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      ld_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else if (state == IDLE) begin
      if (req) begin
        cnt   <= WAIT_W'(WAIT_STATES);
        state <= BUSY;
      end
    end else if (state == BUSY) begin
      if (cnt != '0) cnt <= cnt - 1'b1;
      else begin
        state <= DONE;
        mis_q <= mis;
        ld_q  <= MemRead_m && !MemWrite_m && !mis;
        if (MemRead_m && !MemWrite_m && !mis) rdata_q <= mem[idx];
      end
    end else
      state <= IDLE;
  end
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
  end
endmodule
